ram_arbiter: RTL and testbench

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arbiter_pkg.sv | 24 ++
 rtl/ram_arbiter_rr_arbiter2.sv | 58 +++++
 rtl/ram_arbiter.sv | 176 +++++++++++++++++
 tb/tb_ram_arbiter.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arbiter_pkg.sv
// ram_arbiter_pkg
// Shared definitions for the RAM arbiter: default data/address widths, the
// derived memory depth, and the state encoding of the clear sequencer.
package ram_arbiter_pkg;

    // Default data width of one RAM word.
    localparam int unsigned DefSize     = 8;
    // Default address width; the memory holds 1 << DefAddrSize words.
    localparam int unsigned DefAddrSize = 5;
    // Number of words cleared by an init sequence at the default address width.
    localparam int unsigned DefDepth    = 1 << DefAddrSize;

    // IDLE: arbitrating between requesters. CLEAR: walking the RAM writing zeros.
    typedef enum logic [0:0] {
        StIdle  = 1'b0,
        StClear = 1'b1
    } arb_state_e;

    // Depth of a RAM addressed by addr_size bits.
    function automatic int unsigned depth_of(input int unsigned addr_size);
        return 1 << addr_size;
    endfunction

endpackage

// File: rtl/ram_arbiter_rr_arbiter2.sv
// rr_arbiter2
// Two-way round-robin arbiter. Grants are combinational from the requests;
// the fairness pointer remembers which side won most recently and only moves
// when a grant is actually issued.
//
// Ports:
//   clock   in   single clock, state on posedge
//   resetN  in   synchronous active-low reset; pointer returns to "B last"
//   reqA    in   side A requests
//   reqB    in   side B requests
//   enable  in   arbitration allowed this cycle; no grant and no pointer move when low
//   gntA    out  side A granted this cycle
//   gntB    out  side B granted this cycle
module rr_arbiter2 (
    input  logic clock,
    input  logic resetN,
    input  logic reqA,
    input  logic reqB,
    input  logic enable,
    output logic gntA,
    output logic gntB
);

    // 1: A was granted most recently, so B wins the next tie.
    logic last_a_q, last_a_d;

    always_comb begin
        gntA = 1'b0;
        gntB = 1'b0;
        if (enable) begin
            if (reqA && reqB) begin
                gntA = ~last_a_q;
                gntB = last_a_q;
            end else begin
                gntA = reqA;
                gntB = reqB;
            end
        end
    end

    always_comb begin
        last_a_d = last_a_q;
        if (gntA) begin
            last_a_d = 1'b1;
        end else if (gntB) begin
            last_a_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetN) begin
            last_a_q <= 1'b0;
        end else begin
            last_a_q <= last_a_d;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter
// Shares one single-port synchronous RAM between an instruction-side
// requester (A) and a data-side requester (B), and can zero the whole RAM on
// request. At most one RAM access happens per cycle: a clear write, an A
// access or a B access. Grants are combinational; read data comes back one
// cycle after the grant, straight from the RAM's registered output.
//
// Ports:
//   clock     in   single clock, all state on posedge
//   resetN    in   synchronous active-low reset
//   initReq   in   one-cycle pulse starting a full RAM clear (ignored while clearing)
//   initBusy  out  clear in progress
//   aReq/bReq       in   access request, held with its fields until granted
//   aWe/bWe         in   1 = write, 0 = read
//   aAddr/bAddr     in   word address
//   aWData/bWData   in   write data
//   aGnt/bGnt       out  access issued to the RAM this cycle
//   aRValid/bRValid out  read data valid (cycle after a read grant)
//   aRData/bRData   out  read data (RAM output passed through)
//   ramWE     out  RAM write enable
//   ramD      out  RAM write data
//   ramAddr   out  RAM address
//   ramQ      in   RAM registered read data
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int unsigned SIZE      = DefSize,
    parameter int unsigned ADDR_SIZE = DefAddrSize
) (
    input  logic                 clock,
    input  logic                 resetN,
    input  logic                 initReq,
    output logic                 initBusy,
    input  logic                 aReq,
    input  logic                 aWe,
    input  logic [ADDR_SIZE-1:0] aAddr,
    input  logic [SIZE-1:0]      aWData,
    output logic                 aGnt,
    output logic                 aRValid,
    output logic [SIZE-1:0]      aRData,
    input  logic                 bReq,
    input  logic                 bWe,
    input  logic [ADDR_SIZE-1:0] bAddr,
    input  logic [SIZE-1:0]      bWData,
    output logic                 bGnt,
    output logic                 bRValid,
    output logic [SIZE-1:0]      bRData,
    output logic                 ramWE,
    output logic [SIZE-1:0]      ramD,
    output logic [ADDR_SIZE-1:0] ramAddr,
    input  logic [SIZE-1:0]      ramQ
);

    localparam int unsigned DEPTH = depth_of(ADDR_SIZE);
    localparam logic [ADDR_SIZE-1:0] LastAddr = ADDR_SIZE'(DEPTH - 1);

    arb_state_e           state_q, state_d;
    logic [ADDR_SIZE-1:0] clr_addr_q, clr_addr_d;
    logic                 a_rvalid_q, a_rvalid_d;
    logic                 b_rvalid_q, b_rvalid_d;

    logic arb_en;
    logic arb_gnt_a;
    logic arb_gnt_b;

    // ------------------------------------------------------------------
    // Clear sequencer
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        unique case (state_q)
            StIdle: begin
                if (initReq) begin
                    state_d    = StClear;
                    clr_addr_d = '0;
                end
            end
            StClear: begin
                // initReq is deliberately not looked at here: a clear runs to completion.
                if (clr_addr_q == LastAddr) begin
                    state_d    = StIdle;
                    clr_addr_d = '0;
                end else begin
                    clr_addr_d = clr_addr_q + ADDR_SIZE'(1);
                end
            end
            default: begin
                state_d    = StIdle;
                clr_addr_d = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetN) begin
            state_q    <= StIdle;
            clr_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
        end
    end

    // ------------------------------------------------------------------
    // Arbitration: only in IDLE, and a starting clear pre-empts any grant.
    // ------------------------------------------------------------------
    assign arb_en = resetN && (state_q == StIdle) && !initReq;

    rr_arbiter2 u_rr (
        .clock  (clock),
        .resetN (resetN),
        .reqA   (aReq),
        .reqB   (bReq),
        .enable (arb_en),
        .gntA   (arb_gnt_a),
        .gntB   (arb_gnt_b)
    );

    // ------------------------------------------------------------------
    // RAM port mux and grants. Everything is forced quiet while in reset.
    // ------------------------------------------------------------------
    always_comb begin
        ramWE    = 1'b0;
        ramAddr  = '0;
        ramD     = '0;
        aGnt     = 1'b0;
        bGnt     = 1'b0;
        initBusy = 1'b0;
        if (resetN) begin
            if (state_q == StClear) begin
                ramWE    = 1'b1;
                ramAddr  = clr_addr_q;
                initBusy = 1'b1;
            end else if (arb_gnt_a) begin
                aGnt    = 1'b1;
                ramWE   = aWe;
                ramAddr = aAddr;
                ramD    = aWData;
            end else if (arb_gnt_b) begin
                bGnt    = 1'b1;
                ramWE   = bWe;
                ramAddr = bAddr;
                ramD    = bWData;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read-return tracking: RAM output is registered, so data for a read
    // granted now appears on ramQ next cycle.
    // ------------------------------------------------------------------
    always_comb begin
        a_rvalid_d = aGnt && !aWe;
        b_rvalid_d = bGnt && !bWe;
    end

    always_ff @(posedge clock) begin
        if (!resetN) begin
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
        end else begin
            a_rvalid_q <= a_rvalid_d;
            b_rvalid_q <= b_rvalid_d;
        end
    end

    // A read issued just before reset asserts must not be reported during reset either.
    assign aRValid = a_rvalid_q && resetN;
    assign bRValid = b_rvalid_q && resetN;

    // Data is only meaningful alongside RValid, so no extra muxing is needed.
    assign aRData = ramQ;
    assign bRData = ramQ;

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: a directed vector table, hand-written
// clear/reset sequences, and randomized traffic checked against a
// transaction-level model (memory image, clear countdown, last winner).
module tb_ram_arbiter;

    localparam int DEPTH = 32;

    logic       clock = 1'b0;
    logic       resetN;
    logic       initReq;
    logic       initBusy;
    logic       aReq, aWe, bReq, bWe;
    logic [4:0] aAddr, bAddr;
    logic [7:0] aWData, bWData;
    logic       aGnt, aRValid, bGnt, bRValid;
    logic [7:0] aRData, bRData;
    logic       ramWE;
    logic [7:0] ramD;
    logic [4:0] ramAddr;
    logic [7:0] ramQ;

    always #5 clock = ~clock;

    ram_arbiter dut (
        .clock    (clock),
        .resetN   (resetN),
        .initReq  (initReq),
        .initBusy (initBusy),
        .aReq     (aReq),
        .aWe      (aWe),
        .aAddr    (aAddr),
        .aWData   (aWData),
        .aGnt     (aGnt),
        .aRValid  (aRValid),
        .aRData   (aRData),
        .bReq     (bReq),
        .bWe      (bWe),
        .bAddr    (bAddr),
        .bWData   (bWData),
        .bGnt     (bGnt),
        .bRValid  (bRValid),
        .bRData   (bRData),
        .ramWE    (ramWE),
        .ramD     (ramD),
        .ramAddr  (ramAddr),
        .ramQ     (ramQ)
    );

    // Single-port RAM with registered, read-first output.
    logic [7:0] mem [DEPTH];
    always @(posedge clock) begin
        if (ramWE) mem[ramAddr] <= ramD;
        ramQ <= mem[ramAddr];
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] model_mem [DEPTH];
    int         clr_left = 0;    // clear writes still to do
    bit         last_a   = 1'b0; // A won most recently
    bit         pend_a   = 1'b0, pend_b = 1'b0;
    logic [7:0] exp_a_data, exp_b_data;
    bit         e_ag, e_bg, e_we, e_busy, e_arv, e_brv;
    logic [4:0] e_addr;
    logic [7:0] e_d;

    // Called just after the negedge with inputs driven: settle, predict, optionally check.
    task automatic settle_eval(input bit do_chk);
        #1;
        e_ag = 0; e_bg = 0; e_we = 0; e_addr = '0; e_d = '0;
        e_busy = resetN && (clr_left > 0);
        e_arv  = resetN && pend_a;
        e_brv  = resetN && pend_b;
        if (resetN) begin
            if (clr_left > 0) begin
                e_we   = 1;
                e_addr = 5'(DEPTH - clr_left);
            end else if (!initReq) begin
                if (aReq && (!bReq || !last_a)) e_ag = 1;
                else if (bReq) e_bg = 1;
                if (e_ag) begin e_we = aWe; e_addr = aAddr; e_d = aWData; end
                if (e_bg) begin e_we = bWe; e_addr = bAddr; e_d = bWData; end
            end
        end
        if (do_chk) begin
            chk("m_aGnt",     32'(aGnt),     32'(e_ag));
            chk("m_bGnt",     32'(bGnt),     32'(e_bg));
            chk("m_ramWE",    32'(ramWE),    32'(e_we));
            chk("m_ramAddr",  32'(ramAddr),  32'(e_addr));
            chk("m_ramD",     32'(ramD),     32'(e_d));
            chk("m_initBusy", 32'(initBusy), 32'(e_busy));
            chk("m_aRValid",  32'(aRValid),  32'(e_arv));
            chk("m_bRValid",  32'(bRValid),  32'(e_brv));
            if (e_arv) chk("m_aRData", 32'(aRData), 32'(exp_a_data));
            if (e_brv) chk("m_bRData", 32'(bRData), 32'(exp_b_data));
        end
    endtask

    // Clock the DUT and the model together, return just after the next negedge.
    task automatic advance();
        @(posedge clock);
        if (!resetN) begin
            clr_left = 0; last_a = 0; pend_a = 0; pend_b = 0;
        end else begin
            pend_a = e_ag && !aWe;
            pend_b = e_bg && !bWe;
            if (e_ag) exp_a_data = model_mem[aAddr];
            if (e_bg) exp_b_data = model_mem[bAddr];
            if (clr_left > 0) begin
                model_mem[e_addr] = 8'h00;
                clr_left--;
            end else if (initReq) begin
                clr_left = DEPTH;
            end else if (e_ag) begin
                last_a = 1;
                if (aWe) model_mem[aAddr] = aWData;
            end else if (e_bg) begin
                last_a = 0;
                if (bWe) model_mem[bAddr] = bWData;
            end
        end
        @(negedge clock);
    endtask

    task automatic quiet();
        initReq = 0;
        aReq = 0; aWe = 0; aAddr = '0; aWData = '0;
        bReq = 0; bWe = 0; bAddr = '0; bWData = '0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic rst_n, init;
        logic a_req, a_we; logic [4:0] a_addr; logic [7:0] a_wd;
        logic b_req, b_we; logic [4:0] b_addr; logic [7:0] b_wd;
        logic ag, bg, we; logic [4:0] addr; logic [7:0] d;
        logic arv, brv; logic [7:0] rd;
    } vec_t;

    vec_t vt [14];

    initial begin
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 8'h00;
        resetN = 0;
        quiet();

        //         rst init aR aW aA  aD     bR bW bA  bD     ag bg we addr d      arv brv rd
        vt[0]  = '{0, 0,   1, 1, 3, 8'h5A, 0, 0, 0, 8'h00, 0, 0, 0, 0,  8'h00, 0, 0, 8'h00};
        vt[1]  = '{1, 0,   1, 1, 3, 8'h5A, 0, 0, 0, 8'h00, 1, 0, 1, 3,  8'h5A, 0, 0, 8'h00};
        vt[2]  = '{1, 0,   1, 0, 3, 8'h00, 0, 0, 0, 8'h00, 1, 0, 0, 3,  8'h00, 0, 0, 8'h00};
        vt[3]  = '{1, 0,   0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 0,  8'h00, 1, 0, 8'h5A};
        vt[4]  = '{0, 0,   0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 0,  8'h00, 0, 0, 8'h00};
        vt[5]  = '{1, 0,   1, 0, 3, 8'h00, 1, 0, 3, 8'h00, 1, 0, 0, 3,  8'h00, 0, 0, 8'h00};
        vt[6]  = '{1, 0,   1, 0, 3, 8'h00, 1, 0, 3, 8'h00, 0, 1, 0, 3,  8'h00, 1, 0, 8'h5A};
        vt[7]  = '{1, 0,   1, 0, 3, 8'h00, 1, 0, 3, 8'h00, 1, 0, 0, 3,  8'h00, 0, 1, 8'h5A};
        vt[8]  = '{1, 0,   1, 0, 3, 8'h00, 1, 0, 3, 8'h00, 0, 1, 0, 3,  8'h00, 1, 0, 8'h5A};
        vt[9]  = '{1, 0,   0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 0,  8'h00, 0, 1, 8'h5A};
        vt[10] = '{1, 0,   0, 0, 0, 8'h00, 1, 1, 7, 8'hC3, 0, 1, 1, 7,  8'hC3, 0, 0, 8'h00};
        vt[11] = '{1, 0,   1, 1, 9, 8'h11, 1, 0, 7, 8'h00, 1, 0, 1, 9,  8'h11, 0, 0, 8'h00};
        vt[12] = '{1, 0,   0, 0, 0, 8'h00, 1, 0, 7, 8'h00, 0, 1, 0, 7,  8'h00, 0, 0, 8'h00};
        vt[13] = '{1, 0,   0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 0,  8'h00, 0, 1, 8'hC3};

        for (int i = 0; i < 14; i++) begin
            resetN = vt[i].rst_n; initReq = vt[i].init;
            aReq = vt[i].a_req; aWe = vt[i].a_we; aAddr = vt[i].a_addr; aWData = vt[i].a_wd;
            bReq = vt[i].b_req; bWe = vt[i].b_we; bAddr = vt[i].b_addr; bWData = vt[i].b_wd;
            settle_eval(0);
            chk($sformatf("v%0d_aGnt", i),     32'(aGnt),     32'(vt[i].ag));
            chk($sformatf("v%0d_bGnt", i),     32'(bGnt),     32'(vt[i].bg));
            chk($sformatf("v%0d_ramWE", i),    32'(ramWE),    32'(vt[i].we));
            chk($sformatf("v%0d_ramAddr", i),  32'(ramAddr),  32'(vt[i].addr));
            chk($sformatf("v%0d_ramD", i),     32'(ramD),     32'(vt[i].d));
            chk($sformatf("v%0d_aRValid", i),  32'(aRValid),  32'(vt[i].arv));
            chk($sformatf("v%0d_bRValid", i),  32'(bRValid),  32'(vt[i].brv));
            chk($sformatf("v%0d_initBusy", i), 32'(initBusy), 32'(0));
            if (vt[i].arv) chk($sformatf("v%0d_aRData", i), 32'(aRData), 32'(vt[i].rd));
            if (vt[i].brv) chk($sformatf("v%0d_bRData", i), 32'(bRData), 32'(vt[i].rd));
            advance();
        end

        // ---- Full clear with A read held throughout; mid-clear initReq ignored ----
        quiet();
        aReq = 1; aWe = 0; aAddr = 5'd5; aWData = 8'h77;
        initReq = 1;
        settle_eval(1);
        chk("clr_start_aGnt", 32'(aGnt), 32'(0));
        advance();
        for (int i = 0; i < DEPTH; i++) begin
            initReq = (i == 5);
            settle_eval(1);
            chk($sformatf("clr%0d_busy", i), 32'(initBusy), 32'(1));
            chk($sformatf("clr%0d_we", i),   32'(ramWE),    32'(1));
            chk($sformatf("clr%0d_addr", i), 32'(ramAddr),  32'(i));
            chk($sformatf("clr%0d_d", i),    32'(ramD),     32'(0));
            chk($sformatf("clr%0d_aGnt", i), 32'(aGnt),     32'(0));
            advance();
        end
        initReq = 0;
        settle_eval(1);
        chk("clr_done_busy", 32'(initBusy), 32'(0));
        chk("clr_done_aGnt", 32'(aGnt),     32'(1));
        advance();
        aReq = 0;
        settle_eval(1);
        chk("clr_rd_valid", 32'(aRValid), 32'(1));
        chk("clr_rd_data",  32'(aRData),  32'(0));
        advance();

        // ---- Reset in the middle of a clear, then restart from address 0 ----
        initReq = 1;
        settle_eval(1);
        advance();
        initReq = 0;
        for (int i = 0; i < 10; i++) begin
            settle_eval(1);
            advance();
        end
        settle_eval(1);
        chk("abort_addr10", 32'(ramAddr), 32'(10));
        resetN = 0;
        settle_eval(1);
        chk("abort_rst_busy", 32'(initBusy), 32'(0));
        chk("abort_rst_we",   32'(ramWE),    32'(0));
        advance();
        resetN = 1;
        settle_eval(1);
        chk("abort_after_busy", 32'(initBusy), 32'(0));
        chk("abort_after_we",   32'(ramWE),    32'(0));
        advance();
        initReq = 1;
        settle_eval(1);
        advance();
        initReq = 0;
        settle_eval(1);
        chk("restart_addr", 32'(ramAddr),  32'(0));
        chk("restart_busy", 32'(initBusy), 32'(1));
        advance();
        for (int i = 1; i < DEPTH; i++) begin
            settle_eval(1);
            advance();
        end

        // ---- initReq and bReq together: clear wins, B served right after ----
        bReq = 1; bWe = 0; bAddr = 5'd9; bWData = 8'h00;
        initReq = 1;
        settle_eval(1);
        chk("ib_same_bGnt", 32'(bGnt), 32'(0));
        advance();
        initReq = 0;
        for (int i = 0; i < DEPTH; i++) begin
            settle_eval(1);
            advance();
        end
        settle_eval(1);
        chk("ib_after_bGnt", 32'(bGnt), 32'(1));
        advance();
        bReq = 0;
        settle_eval(1);
        chk("ib_rd_valid", 32'(bRValid), 32'(1));
        chk("ib_rd_data",  32'(bRData),  32'(0));
        advance();

        // ---- Randomized traffic against the model ----
        for (int c = 0; c < 1500; c++) begin
            if (!aReq || e_ag) begin
                aReq   = ($urandom_range(0, 3) != 0);
                aWe    = ($urandom_range(0, 1) != 0);
                aAddr  = 5'($urandom_range(0, DEPTH - 1));
                aWData = 8'($urandom_range(0, 255));
            end
            if (!bReq || e_bg) begin
                bReq   = ($urandom_range(0, 3) != 0);
                bWe    = ($urandom_range(0, 1) != 0);
                bAddr  = 5'($urandom_range(0, DEPTH - 1));
                bWData = 8'($urandom_range(0, 255));
            end
            initReq = ($urandom_range(0, 99) == 0);
            resetN  = ($urandom_range(0, 199) != 0);
            settle_eval(1);
            advance();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
